// File: rtl/bcd_display_ctrl.sv
// rtl/bcd_display_ctrl.sv - sequential binary-to-BCD converter with seven-segment driver
module bcd_display_ctrl #(
    parameter int IN_WIDTH       = 11,
    parameter int NUM_DIGITS     = 4,
    parameter int SIGNED         = 0,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_WIDTH-1:0]     value,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    negative,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] segments
);

    localparam int INT_DIGITS = (IN_WIDTH + 2) / 3;
    localparam int EXT_DIGITS = (NUM_DIGITS > INT_DIGITS) ? NUM_DIGITS : INT_DIGITS;
    localparam int CNT_W      = $clog2(IN_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    typedef enum logic [1:0] {IDLE, ADD3, SHIFT, DONE} state_t;

    state_t                    state, state_next;
    logic [IN_WIDTH-1:0]       mag_reg;
    logic [4*INT_DIGITS-1:0]   bcd_reg;
    logic [4*INT_DIGITS-1:0]   bcd_add3;
    logic [CNT_W-1:0]          cnt;
    logic                      sign_reg;
    logic                      value_neg;
    logic [IN_WIDTH-1:0]       magnitude_in;

    logic [3:0]                ext [EXT_DIGITS];
    logic                      ovf_next;
    logic [4*NUM_DIGITS-1:0]   bcd_next;
    logic [7*NUM_DIGITS-1:0]   seg_next;
    int                        msd;
    int                        sign_pos;

    // Active-high {g,f,e,d,c,b,a} pattern for a decimal digit; non-decimal codes are blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] polarity(input logic [6:0] s);
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    // Display pattern after reset: "0" in digit 0, the rest blank or "0".
    function automatic logic [7*NUM_DIGITS-1:0] reset_segments();
        logic [7*NUM_DIGITS-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[7*i +: 7] = polarity((i == 0 || BLANK_LEADING == 0) ? SEG_ZERO : SEG_BLANK);
        end
        return r;
    endfunction

    assign in_ready = (state == IDLE);

    // Magnitude captured at accept; negation wraps in IN_WIDTH bits so the most negative value maps to 2^(IN_WIDTH-1).
    always_comb begin
        value_neg    = (SIGNED != 0) && value[IN_WIDTH-1];
        magnitude_in = value_neg ? (~value + 1'b1) : value;
    end

    // Add 3 to every BCD digit above 4, digits independent.
    always_comb begin
        bcd_add3 = bcd_reg;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] > 4'd4) begin
                bcd_add3[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ADD3;
            ADD3:    state_next = SHIFT;
            SHIFT:   state_next = (cnt == LAST_ITER) ? DONE : ADD3;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Conversion datapath: capture, add-3 and shift steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_reg  <= '0;
            bcd_reg  <= '0;
            cnt      <= '0;
            sign_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_reg  <= magnitude_in;
                        sign_reg <= value_neg;
                        bcd_reg  <= '0;
                        cnt      <= '0;
                    end
                end
                ADD3: bcd_reg <= bcd_add3;
                SHIFT: begin
                    {bcd_reg, mag_reg} <= {bcd_reg, mag_reg} << 1;
                    cnt                <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Overflow detection and digit-to-segment mapping of the finished BCD value.
    always_comb begin
        ovf_next = 1'b0;
        msd      = 0;
        bcd_next = '0;
        seg_next = '0;
        for (int i = 0; i < EXT_DIGITS; i++) begin
            ext[i] = (i < INT_DIGITS) ? bcd_reg[4*i +: 4] : 4'd0;
        end
        for (int i = 0; i < EXT_DIGITS; i++) begin
            if (i >= NUM_DIGITS && ext[i] != 4'd0) ovf_next = 1'b1;
            if (sign_reg && i >= NUM_DIGITS - 1 && ext[i] != 4'd0) ovf_next = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ext[i] != 4'd0) msd = i;
        end
        sign_pos = (BLANK_LEADING != 0) ? msd + 1 : NUM_DIGITS - 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_next) begin
                bcd_next[4*i +: 4] = 4'd9;
                seg_next[7*i +: 7] = polarity(SEG_MINUS);
            end else begin
                bcd_next[4*i +: 4] = ext[i];
                if (sign_reg && i == sign_pos) begin
                    seg_next[7*i +: 7] = polarity(SEG_MINUS);
                end else if (BLANK_LEADING != 0 && i > msd) begin
                    seg_next[7*i +: 7] = polarity(SEG_BLANK);
                end else begin
                    seg_next[7*i +: 7] = polarity(seg_digit(ext[i]));
                end
            end
        end
    end

    // Result latches, updated only on the edge leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bcd       <= '0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            segments  <= reset_segments();
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE) begin
                bcd      <= bcd_next;
                negative <= sign_reg;
                overflow <= ovf_next;
                segments <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb/tb_bcd_display_ctrl.sv - directed self-checking bench for bcd_display_ctrl
module tb_bcd_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] value;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  negative;
    logic [3:0]  overflow;
    logic [15:0] bcd_a, bcd_b, bcd_s;
    logic [11:0] bcd_c;
    logic [27:0] seg_a, seg_b, seg_s;
    logic [20:0] seg_c;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_display_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .value(value), .out_valid(out_valid[0]), .bcd(bcd_a), .negative(negative[0]),
        .overflow(overflow[0]), .segments(seg_a)
    );

    bcd_display_ctrl #(.BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .value(value), .out_valid(out_valid[1]), .bcd(bcd_b), .negative(negative[1]),
        .overflow(overflow[1]), .segments(seg_b)
    );

    bcd_display_ctrl #(.NUM_DIGITS(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .value(value), .out_valid(out_valid[2]), .bcd(bcd_c), .negative(negative[2]),
        .overflow(overflow[2]), .segments(seg_c)
    );

    bcd_display_ctrl #(.SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .value(value), .out_valid(out_valid[3]), .bcd(bcd_s), .negative(negative[3]),
        .overflow(overflow[3]), .segments(seg_s)
    );

    // Present v to DUT d for one accept edge; lat = negedges until out_valid (-1 on timeout).
    task automatic convert(input int d, input logic [10:0] v, output int lat);
        @(negedge clk);
        value       = v;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (out_valid[d]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (bcd_a !== 16'h0) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd_a); end
        checks++; if (seg_a !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL reset_seg_a got %h", seg_a); end
        checks++; if (seg_b !== {7'h40, 7'h40, 7'h40, 7'h40}) begin errors++; $display("FAIL reset_seg_b got %h", seg_b); end
        checks++; if (seg_c !== {7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL reset_seg_c got %h", seg_c); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %b want 1111", in_ready); end
        checks++; if (out_valid !== 4'h0 || negative !== 4'h0 || overflow !== 4'h0) begin
            errors++; $display("FAIL reset_flags got ov=%b neg=%b ovf=%b want 0", out_valid, negative, overflow);
        end
    endtask

    task automatic test_max();
        int lat;
        convert(0, 11'd2047, lat);
        checks++; if (lat != 24) begin errors++; $display("FAIL max_latency got %0d want 24", lat); end
        checks++; if (bcd_a !== 16'h2047) begin errors++; $display("FAIL max_bcd got %h want 2047", bcd_a); end
        checks++; if (seg_a !== {7'h24, 7'h40, 7'h19, 7'h78}) begin errors++; $display("FAIL max_seg got %h", seg_a); end
        checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL max_ovf got %b want 0", overflow[0]); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL max_ready got %b want 1", in_ready[0]); end
        @(negedge clk);
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL max_pulse got %b want 0", out_valid[0]); end
        checks++; if (bcd_a !== 16'h2047) begin errors++; $display("FAIL max_hold got %h want 2047", bcd_a); end
    endtask

    task automatic test_zero();
        int lat;
        convert(0, 11'd0, lat);
        checks++; if (lat != 24 || bcd_a !== 16'h0) begin errors++; $display("FAIL zero_bcd got %h lat %0d want 0000 lat 24", bcd_a, lat); end
        checks++; if (seg_a !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL zero_seg got %h", seg_a); end
        convert(1, 11'd0, lat);
        checks++; if (lat != 24 || seg_b !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            errors++; $display("FAIL zero_noblank_seg got %h lat %0d", seg_b, lat);
        end
        convert(1, 11'd5, lat);
        checks++; if (bcd_b !== 16'h0005 || seg_b !== {7'h40, 7'h40, 7'h40, 7'h12}) begin
            errors++; $display("FAIL five_noblank got bcd %h seg %h", bcd_b, seg_b);
        end
    endtask

    task automatic test_overflow();
        int lat;
        convert(2, 11'd1000, lat);
        checks++; if (lat != 24 || overflow[2] !== 1'b1) begin errors++; $display("FAIL ovf1000_flag got %b lat %0d want 1", overflow[2], lat); end
        checks++; if (bcd_c !== 12'h999) begin errors++; $display("FAIL ovf1000_bcd got %h want 999", bcd_c); end
        checks++; if (seg_c !== {7'h3F, 7'h3F, 7'h3F}) begin errors++; $display("FAIL ovf1000_seg got %h", seg_c); end
        convert(2, 11'd999, lat);
        checks++; if (overflow[2] !== 1'b0) begin errors++; $display("FAIL fit999_flag got %b want 0", overflow[2]); end
        checks++; if (bcd_c !== 12'h999 || seg_c !== {7'h10, 7'h10, 7'h10}) begin
            errors++; $display("FAIL fit999_out got bcd %h seg %h", bcd_c, seg_c);
        end
    endtask

    task automatic test_signed();
        int lat;
        convert(3, 11'h7F6, lat);
        checks++; if (lat != 24 || negative[3] !== 1'b1 || overflow[3] !== 1'b0) begin
            errors++; $display("FAIL neg10_flags got neg %b ovf %b lat %0d want 1 0", negative[3], overflow[3], lat);
        end
        checks++; if (bcd_s !== 16'h0010) begin errors++; $display("FAIL neg10_bcd got %h want 0010", bcd_s); end
        checks++; if (seg_s !== {7'h7F, 7'h3F, 7'h79, 7'h40}) begin errors++; $display("FAIL neg10_seg got %h", seg_s); end
        convert(3, 11'h07B, lat);
        checks++; if (negative[3] !== 1'b0 || bcd_s !== 16'h0123 || seg_s !== {7'h7F, 7'h79, 7'h24, 7'h30}) begin
            errors++; $display("FAIL pos123 got neg %b bcd %h seg %h", negative[3], bcd_s, seg_s);
        end
        convert(3, 11'h400, lat);
        checks++; if (overflow[3] !== 1'b1 || bcd_s !== 16'h9999) begin
            errors++; $display("FAIL neg1024 got ovf %b bcd %h want 1 9999", overflow[3], bcd_s);
        end
        checks++; if (seg_s !== {7'h3F, 7'h3F, 7'h3F, 7'h3F}) begin errors++; $display("FAIL neg1024_seg got %h", seg_s); end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        @(negedge clk);
        value       = 11'd1234;
        in_valid[0] = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                lat = c;
                break;
            end
            value = 11'(300 + c * 37);
        end
        checks++; if (lat != 24 || bcd_a !== 16'h1234) begin errors++; $display("FAIL b2b_first got bcd %h lat %0d want 1234 lat 24", bcd_a, lat); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready[0]); end
        value = 11'd56;
        gap = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                gap = c;
                break;
            end
            if (c == 1) begin
                in_valid[0] = 1'b0;
                value       = 11'd999;
            end
        end
        in_valid[0] = 1'b0;
        checks++; if (gap != 24 || bcd_a !== 16'h0056) begin errors++; $display("FAIL b2b_second got bcd %h gap %0d want 0056 gap 24", bcd_a, gap); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        value       = 11'd1500;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bcd_a !== 16'h0 || seg_a !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            errors++; $display("FAIL abort_outputs got bcd %h seg %h", bcd_a, seg_a);
        end
        checks++; if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL abort_handshake got ready %b ov %b want 1 0", in_ready[0], out_valid[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) pulses++;
        end
        checks++; if (pulses != 0 || bcd_a !== 16'h0) begin errors++; $display("FAIL abort_no_pulse got %0d pulses bcd %h want 0", pulses, bcd_a); end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 4'h0;
        value    = 11'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_max();
        test_zero();
        test_overflow();
        test_signed();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
